// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU-side types used by the memory arbiter and its neighbours.
//   word_t      : 32-bit machine word
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : memory arbiter grant state
//   BAD_DATA    : load value returned when an access ends in error or timeout
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DGRANT = 2'b01,
        IGRANT = 2'b10
    } arb_state_t;

    localparam word_t BAD_DATA = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_watchdog.sv
// ----------------------------------------------------------------------------
// arb_watchdog
//   Counts cycles spent in a grant state and flags the cycle on which the
//   access must be forcibly ended.
//   Ports:
//     CLK       in  clock, rising edge
//     nRST      in  asynchronous active-low reset
//     clr_i     in  return count to zero (has priority over inc_i)
//     inc_i     in  advance count by one
//     expire_o  out count has reached TIMEOUT_CYC-1
// ----------------------------------------------------------------------------
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT_CYC) + 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The owner is always cleared or leaves the grant state on the expiring
    // cycle, so the count never runs past TIMEOUT_CYC-1.
    assign expire_o = (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single RAM port between instruction fetch and data accesses.
//   Data wins by default; after MAX_DSTREAK consecutive data completions with
//   a fetch waiting, the fetch gets the next grant. A watchdog ends accesses
//   that stay in FREE/BUSY for TIMEOUT_CYC grant cycles.
//   Ports:
//     CLK, nRST                  clock / async active-low reset
//     iREN, iaddr                fetch request and word address
//     iwait, iload               fetch handshake (0 = done) and data
//     dREN, dWEN, daddr, dstore  data request (write wins), address, data
//     dwait, dload               data handshake (0 = done) and read data
//     ramREN, ramWEN, ramaddr,
//     ramstore                   RAM command, driven from latched request
//     ramload, ramstate          RAM read data and status
//     err                        one-cycle pulse on RAM error or timeout
// ----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

    arb_state_t  state_q,  state_d;
    word_t       addr_q,   addr_d;
    word_t       store_q,  store_d;
    logic        wflag_q,  wflag_d;
    logic [3:0]  streak_q, streak_d;

    ramstate_t   rs;
    logic        data_req;
    logic        wd_clr;
    logic        wd_inc;
    logic        wd_expire;
    logic        d_done;
    logic        i_done;

    assign rs       = ramstate_t'(ramstate);
    assign data_req = dREN | dWEN;

    arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .clr_i    (wd_clr),
        .inc_i    (wd_inc),
        .expire_o (wd_expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wflag_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wflag_q  <= wflag_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wflag_d  = wflag_q;
        streak_d = streak_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        err      = 1'b0;
        wd_clr   = 1'b0;
        wd_inc   = 1'b0;
        d_done   = 1'b0;
        i_done   = 1'b0;

        case (state_q)
            IDLE: begin
                wd_clr = 1'b1;
                // Data yields only when a fetch is waiting and the streak is spent.
                if (data_req && !(iREN && (streak_q == MAX_S))) begin
                    state_d = DGRANT;
                    addr_d  = daddr;
                    store_d = dstore;
                    wflag_d = dWEN;
                end else if (iREN) begin
                    state_d = IGRANT;
                    addr_d  = iaddr;
                    store_d = '0;
                    wflag_d = 1'b0;
                end
            end

            DGRANT: begin
                if (!data_req) begin
                    // Request withdrawn: silent abort, enables stay low.
                    state_d = IDLE;
                    wd_clr  = 1'b1;
                end else begin
                    ramWEN   = wflag_q;
                    ramREN   = !wflag_q;
                    ramaddr  = addr_q;
                    ramstore = store_q;
                    case (rs)
                        ACCESS: begin
                            dwait  = 1'b0;
                            dload  = wflag_q ? '0 : ramload;
                            d_done = 1'b1;
                        end
                        ERROR: begin
                            dwait  = 1'b0;
                            dload  = BAD_DATA;
                            err    = 1'b1;
                            d_done = 1'b1;
                        end
                        default: begin
                            if (wd_expire) begin
                                dwait  = 1'b0;
                                dload  = BAD_DATA;
                                err    = 1'b1;
                                d_done = 1'b1;
                            end else begin
                                wd_inc = 1'b1;
                            end
                        end
                    endcase
                    if (d_done) begin
                        state_d = IDLE;
                        wd_clr  = 1'b1;
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                    wd_clr  = 1'b1;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = addr_q;
                    case (rs)
                        ACCESS: begin
                            iwait  = 1'b0;
                            iload  = ramload;
                            i_done = 1'b1;
                        end
                        ERROR: begin
                            iwait  = 1'b0;
                            iload  = BAD_DATA;
                            err    = 1'b1;
                            i_done = 1'b1;
                        end
                        default: begin
                            if (wd_expire) begin
                                iwait  = 1'b0;
                                iload  = BAD_DATA;
                                err    = 1'b1;
                                i_done = 1'b1;
                            end else begin
                                wd_inc = 1'b1;
                            end
                        end
                    endcase
                    if (i_done) begin
                        state_d = IDLE;
                        wd_clr  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                wd_clr  = 1'b1;
            end
        endcase

        // Streak only means something while a fetch is actually waiting.
        if (!iREN) begin
            streak_d = '0;
        end else if (d_done) begin
            if (streak_q < MAX_S) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (i_done) begin
            streak_d = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int          MAXS      = 4;
    localparam int          TMO       = 8;
    localparam logic [1:0]  RS_FREE   = 2'd0;
    localparam logic [1:0]  RS_BUSY   = 2'd1;
    localparam logic [1:0]  RS_ACCESS = 2'd2;
    localparam logic [1:0]  RS_ERROR  = 2'd3;
    localparam logic [31:0] BAD       = 32'hBAD1BAD1;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .MAX_DSTREAK(MAXS),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h4; daddr = 32'h8; dstore = 32'h1; ramload = 32'hFFFF_FFFF; ramstate = RS_ACCESS;
        next_cycle(); next_cycle(); #1;
        n_tests++; if ({ramREN, ramWEN, iwait, dwait, err} !== 5'b00110) begin n_fail++; $display("FAIL reset_ctrl got %b want 00110", {ramREN, ramWEN, iwait, dwait, err}); end
        n_tests++; if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {ramaddr, ramstore, iload, dload}); end
        next_cycle();
        nRST = 1'b1; iREN = 1'b0; dREN = 1'b0;
        #1;
        n_tests++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin n_fail++; $display("FAIL reset_release got %b want 0011", {ramREN, ramWEN, iwait, dwait}); end
        $display("[TB] reset checked");
    endtask

    task automatic test_fetch();
        next_cycle();
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_ACCESS; ramload = 32'h1234_5678;
        #1;
        n_tests++; if ({ramREN, iwait} !== 2'b01) begin n_fail++; $display("FAIL fetch_c0 got %b want 01", {ramREN, iwait}); end
        next_cycle(); #1;
        n_tests++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b1001) begin n_fail++; $display("FAIL fetch_c1_ctrl got %b want 1001", {ramREN, ramWEN, iwait, dwait}); end
        n_tests++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL fetch_addr got %h want 40", ramaddr); end
        n_tests++; if (iload !== 32'h1234_5678 || dload !== 32'h0) begin n_fail++; $display("FAIL fetch_load got %h/%h want 12345678/0", iload, dload); end
        next_cycle();
        iREN = 1'b0;
        #1;
        n_tests++; if ({ramREN, iwait} !== 2'b01) begin n_fail++; $display("FAIL fetch_idle got %b want 01", {ramREN, iwait}); end
        $display("[TB] fetch 0x40 checked");
    endtask

    task automatic test_data_priority();
        next_cycle();
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; iREN = 1'b1; iaddr = 32'h80;
        ramstate = RS_ACCESS; ramload = 32'h5555_AAAA;
        #1;
        n_tests++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin n_fail++; $display("FAIL prio_c0 got %b want 0011", {ramREN, ramWEN, iwait, dwait}); end
        next_cycle(); #1;
        n_tests++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0110) begin n_fail++; $display("FAIL prio_dgrant got %b want 0110", {ramREN, ramWEN, iwait, dwait}); end
        n_tests++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_wr got %h/%h want 100/deadbeef", ramaddr, ramstore); end
        n_tests++; if (dload !== 32'h0 || iload !== 32'h0) begin n_fail++; $display("FAIL prio_loads got %h/%h want 0/0", dload, iload); end
        next_cycle();
        dWEN = 1'b0;
        #1;
        n_tests++; if ({ramREN, ramWEN, iwait} !== 3'b001) begin n_fail++; $display("FAIL prio_idle got %b want 001", {ramREN, ramWEN, iwait}); end
        next_cycle(); #1;
        n_tests++; if ({ramREN, iwait} !== 2'b10 || ramaddr !== 32'h80 || iload !== 32'h5555_AAAA) begin n_fail++; $display("FAIL prio_fetch got %b %h %h want 10 80 5555aaaa", {ramREN, iwait}, ramaddr, iload); end
        next_cycle();
        iREN = 1'b0;
        $display("[TB] data priority write 0x100 then fetch 0x80 checked");
    endtask

    task automatic test_streak();
        bit exp_d, exp_i;
        next_cycle();
        dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300; ramstate = RS_ACCESS; ramload = 32'h0BAD_F00D;
        // Pattern repeats every 10 cycles: four data completions, then the fetch.
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_d = ((c % 10) == 1) || ((c % 10) == 3) || ((c % 10) == 5) || ((c % 10) == 7);
            exp_i = ((c % 10) == 9);
            n_tests++; if (dwait !== !exp_d) begin n_fail++; $display("FAIL streak_dwait cyc %0d got %b want %b", c, dwait, !exp_d); end
            n_tests++; if (iwait !== !exp_i) begin n_fail++; $display("FAIL streak_iwait cyc %0d got %b want %b", c, iwait, !exp_i); end
            next_cycle();
        end
        dREN = 1'b0; iREN = 1'b0;
        $display("[TB] streak of %0d data grants then fetch checked", MAXS);
    endtask

    task automatic test_busy();
        next_cycle();
        dREN = 1'b1; daddr = 32'h204; ramstate = RS_BUSY; ramload = 32'h0;
        #1;
        n_tests++; if ({ramREN, dwait} !== 2'b01) begin n_fail++; $display("FAIL busy_c0 got %b want 01", {ramREN, dwait}); end
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); #1;
            n_tests++; if ({ramREN, dwait, err} !== 3'b110 || ramaddr !== 32'h204) begin n_fail++; $display("FAIL busy_wait cyc %0d got %b %h want 110 204", k, {ramREN, dwait, err}, ramaddr); end
        end
        next_cycle();
        ramstate = RS_ACCESS; ramload = 32'hCAFE_F00D;
        #1;
        n_tests++; if ({dwait, err} !== 2'b00 || dload !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL busy_done got %b %h want 00 cafef00d", {dwait, err}, dload); end
        next_cycle();
        dREN = 1'b0; ramstate = RS_FREE;
        $display("[TB] busy x3 then access checked");
    endtask

    task automatic test_timeout();
        next_cycle();
        dREN = 1'b1; daddr = 32'h308; ramstate = RS_FREE;
        #1;
        for (int k = 1; k < TMO; k++) begin
            next_cycle(); #1;
            n_tests++; if ({dwait, err} !== 2'b10) begin n_fail++; $display("FAIL tmo_wait cyc %0d got %b want 10", k, {dwait, err}); end
        end
        next_cycle(); #1;
        n_tests++; if ({dwait, err} !== 2'b01 || dload !== BAD) begin n_fail++; $display("FAIL tmo_abort got %b %h want 01 bad1bad1", {dwait, err}, dload); end
        next_cycle();
        dREN = 1'b0;
        #1;
        n_tests++; if ({dwait, err} !== 2'b10) begin n_fail++; $display("FAIL tmo_after got %b want 10", {dwait, err}); end
        next_cycle();
        dREN = 1'b1; ramstate = RS_ERROR;
        #1;
        n_tests++; if ({dwait, err} !== 2'b10) begin n_fail++; $display("FAIL ramerr_idle got %b want 10", {dwait, err}); end
        next_cycle(); #1;
        n_tests++; if ({dwait, err} !== 2'b01 || dload !== BAD) begin n_fail++; $display("FAIL ramerr_done got %b %h want 01 bad1bad1", {dwait, err}, dload); end
        next_cycle();
        dREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ramerr_pulse got %b want 0", err); end
        $display("[TB] watchdog at %0d cycles and RAM ERROR checked", TMO);
    endtask

    task automatic test_abort();
        next_cycle();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h55; ramstate = RS_BUSY;
        next_cycle(); #1;
        n_tests++; if ({ramREN, ramWEN} !== 2'b01 || ramstore !== 32'h55) begin n_fail++; $display("FAIL abort_grant got %b %h want 01 55", {ramREN, ramWEN}, ramstore); end
        next_cycle();
        dREN = 1'b0; dWEN = 1'b0;
        #1;
        n_tests++; if ({ramREN, ramWEN, dwait, err} !== 4'b0010) begin n_fail++; $display("FAIL abort_drop got %b want 0010", {ramREN, ramWEN, dwait, err}); end
        next_cycle();
        iREN = 1'b1; iaddr = 32'h20; ramstate = RS_ACCESS; ramload = 32'h99;
        #1;
        n_tests++; if ({ramREN, ramWEN, iwait} !== 3'b001) begin n_fail++; $display("FAIL abort_idle got %b want 001", {ramREN, ramWEN, iwait}); end
        next_cycle(); #1;
        n_tests++; if ({ramREN, iwait} !== 2'b10 || ramaddr !== 32'h20) begin n_fail++; $display("FAIL abort_fetch got %b %h want 10 20", {ramREN, iwait}, ramaddr); end
        next_cycle();
        iREN = 1'b0;
        $display("[TB] dropped data request aborts silently");
    endtask

    task automatic test_async_reset();
        next_cycle();
        dREN = 1'b1; daddr = 32'h400; ramstate = RS_BUSY;
        next_cycle(); #1;
        n_tests++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b want 1", ramREN); end
        #2;
        nRST = 1'b0;
        #1;
        n_tests++; if ({ramREN, ramWEN, iwait, dwait, err} !== 5'b00110 || ramaddr !== 32'h0) begin n_fail++; $display("FAIL arst_now got %b %h want 00110 0", {ramREN, ramWEN, iwait, dwait, err}, ramaddr); end
        next_cycle();
        nRST = 1'b1; dREN = 1'b0; iREN = 1'b1; iaddr = 32'h44; ramstate = RS_ACCESS; ramload = 32'h77;
        #1;
        n_tests++; if ({ramREN, iwait} !== 2'b01) begin n_fail++; $display("FAIL arst_idle got %b want 01", {ramREN, iwait}); end
        next_cycle(); #1;
        n_tests++; if ({ramREN, iwait} !== 2'b10 || ramaddr !== 32'h44 || iload !== 32'h77) begin n_fail++; $display("FAIL arst_fetch got %b %h %h want 10 44 77", {ramREN, iwait}, ramaddr, iload); end
        next_cycle();
        iREN = 1'b0;
        $display("[TB] async reset during busy data grant checked");
    endtask

    // Random traffic against a transaction-level model: who owns the port,
    // how long it has held it, and how many data grants in a row a waiting
    // fetch has had to sit through.
    task automatic test_random();
        bit          d_on, i_on, d_done, i_done, live, m_write;
        int          m_owner, m_age, m_streak, nxt_owner, r, start_fail;
        logic [31:0] m_addr, m_store;
        logic        e_ren, e_wen, e_iwait, e_dwait, e_err;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        d_on = 0; i_on = 0; m_owner = 0; m_age = 0; m_streak = 0;
        m_addr = '0; m_store = '0; m_write = 0;
        start_fail = n_fail;
        next_cycle();
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        next_cycle();
        nRST = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (!d_on) begin
                dREN = 1'b0; dWEN = 1'b0;
                if ($urandom_range(0, 99) < 40) begin
                    d_on = 1; r = $urandom_range(0, 2);
                    dREN = (r != 1); dWEN = (r != 0); daddr = $urandom; dstore = $urandom;
                end
            end else if ($urandom_range(0, 99) < 3) begin
                d_on = 0; dREN = 1'b0; dWEN = 1'b0;
            end
            if (!i_on) begin
                iREN = 1'b0;
                if ($urandom_range(0, 99) < 40) begin
                    i_on = 1; iREN = 1'b1; iaddr = $urandom;
                end
            end else if ($urandom_range(0, 99) < 3) begin
                i_on = 0; iREN = 1'b0;
            end
            r = $urandom_range(0, 99);
            if (c >= 300 && c < 500)
                ramstate = (r < 5) ? RS_ACCESS : (r < 50) ? RS_BUSY : (r < 98) ? RS_FREE : RS_ERROR;
            else
                ramstate = (r < 55) ? RS_ACCESS : (r < 75) ? RS_BUSY : (r < 92) ? RS_FREE : RS_ERROR;
            ramload = $urandom;
            #1;
            e_ren = 0; e_wen = 0; e_iwait = 1; e_dwait = 1; e_err = 0;
            e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
            d_done = 0; i_done = 0; nxt_owner = m_owner;
            if (m_owner == 0) begin
                if ((dREN || dWEN) && !(iREN && m_streak == MAXS)) begin
                    nxt_owner = 1; m_addr = daddr; m_store = dstore; m_write = dWEN;
                end else if (iREN) begin
                    nxt_owner = 2; m_addr = iaddr; m_store = '0; m_write = 0;
                end
            end else begin
                live = (m_owner == 1) ? (dREN || dWEN) : iREN;
                if (!live) begin
                    nxt_owner = 0;
                end else begin
                    e_addr = m_addr;
                    if (m_owner == 1) begin
                        e_ren = !m_write; e_wen = m_write; e_store = m_store;
                    end else begin
                        e_ren = 1;
                    end
                    if (ramstate == RS_ACCESS) begin
                        if (m_owner == 1) begin e_dwait = 0; e_dload = m_write ? 32'h0 : ramload; d_done = 1; end
                        else begin e_iwait = 0; e_iload = ramload; i_done = 1; end
                    end else if (ramstate == RS_ERROR || m_age == TMO - 1) begin
                        e_err = 1;
                        if (m_owner == 1) begin e_dwait = 0; e_dload = BAD; d_done = 1; end
                        else begin e_iwait = 0; e_iload = BAD; i_done = 1; end
                    end
                    if (d_done || i_done) nxt_owner = 0;
                end
            end
            n_tests++; if (ramREN !== e_ren) begin n_fail++; $display("FAIL rnd_ramREN cyc %0d got %b want %b", c, ramREN, e_ren); end
            n_tests++; if (ramWEN !== e_wen) begin n_fail++; $display("FAIL rnd_ramWEN cyc %0d got %b want %b", c, ramWEN, e_wen); end
            n_tests++; if (ramaddr !== e_addr) begin n_fail++; $display("FAIL rnd_ramaddr cyc %0d got %h want %h", c, ramaddr, e_addr); end
            n_tests++; if (ramstore !== e_store) begin n_fail++; $display("FAIL rnd_ramstore cyc %0d got %h want %h", c, ramstore, e_store); end
            n_tests++; if (iwait !== e_iwait) begin n_fail++; $display("FAIL rnd_iwait cyc %0d got %b want %b", c, iwait, e_iwait); end
            n_tests++; if (dwait !== e_dwait) begin n_fail++; $display("FAIL rnd_dwait cyc %0d got %b want %b", c, dwait, e_dwait); end
            n_tests++; if (iload !== e_iload) begin n_fail++; $display("FAIL rnd_iload cyc %0d got %h want %h", c, iload, e_iload); end
            n_tests++; if (dload !== e_dload) begin n_fail++; $display("FAIL rnd_dload cyc %0d got %h want %h", c, dload, e_dload); end
            n_tests++; if (err !== e_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b want %b", c, err, e_err); end
            if (!iREN) m_streak = 0;
            else if (d_done) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            else if (i_done) m_streak = 0;
            m_age = (nxt_owner != 0 && nxt_owner == m_owner) ? m_age + 1 : 0;
            m_owner = nxt_owner;
            if (d_done) d_on = 0;
            if (i_done) i_on = 0;
            next_cycle();
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        $display("[TB] random traffic 800 cycles, %0d new failures", n_fail - start_fail);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_fetch();
        test_data_priority();
        test_streak();
        test_busy();
        test_timeout();
        test_abort();
        test_async_reset();
        test_random();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
